// File: rtl/mutex_system_n.sv
// rtl/mutex_system_n.sv - N-client mutual-exclusion system with starvation/grant counters
// Optional invariant monitor enabled by defining MUTEX_INV_CHECK_EN.
module mutex_system_n #(
  parameter int NUM_CLIENTS  = 3,
  parameter int CLIENT_W     = 2,
  parameter int STARVE_LIMIT = 15,
  parameter int GRANT_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_en,
  input  logic [1:0]               io_rule,
  input  logic [CLIENT_W-1:0]      io_client,
  output logic [2*NUM_CLIENTS-1:0] io_state,
  output logic                     io_x,
  output logic                     io_fired,
  output logic [NUM_CLIENTS-1:0]   io_starve,
  output logic [GRANT_W-1:0]       io_grants,
  output logic                     io_inv_fail
);

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_T = 2'd1,
    ST_C = 2'd2,
    ST_E = 2'd3
  } client_state_t;

  typedef enum logic [1:0] {
    RULE_TRY  = 2'd0,
    RULE_CRIT = 2'd1,
    RULE_EXIT = 2'd2,
    RULE_IDLE = 2'd3
  } rule_t;

  localparam int STARVE_W = 8;

  client_state_t             n_q [NUM_CLIENTS];
  client_state_t             n_d [NUM_CLIENTS];
  logic [STARVE_W-1:0]       starve_q [NUM_CLIENTS];
  logic [STARVE_W-1:0]       starve_d [NUM_CLIENTS];
  logic                      x_q, x_d;
  logic                      fired_q;
  logic [GRANT_W-1:0]        grants_q, grants_d;
  logic [NUM_CLIENTS-1:0]    fire_vec;
  logic                      fire_any;
  logic                      crit_fire;
  rule_t                     rule;

  function automatic logic guard_ok(client_state_t s, rule_t r, logic x);
    logic ok;
    ok = 1'b0;
    case (r)
      RULE_TRY:  ok = (s == ST_I);
      RULE_CRIT: ok = (s == ST_T) && x;
      RULE_EXIT: ok = (s == ST_C);
      RULE_IDLE: ok = (s == ST_E);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign rule = rule_t'(io_rule);

  // A client index at or above NUM_CLIENTS matches no entry, so it never fires.
  always_comb begin
    fire_vec = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      fire_vec[i] = io_en && (io_client == CLIENT_W'(i)) && guard_ok(n_q[i], rule, x_q);
    end
  end

  assign fire_any  = |fire_vec;
  assign crit_fire = fire_any && (rule == RULE_CRIT);

  always_comb begin
    x_d      = x_q;
    grants_d = grants_q;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      n_d[i] = n_q[i];
      if (fire_vec[i]) begin
        case (rule)
          RULE_TRY:  n_d[i] = ST_T;
          RULE_CRIT: n_d[i] = ST_C;
          RULE_EXIT: n_d[i] = ST_E;
          RULE_IDLE: n_d[i] = ST_I;
          default:   n_d[i] = n_q[i];
        endcase
      end
    end
    if (crit_fire) begin
      x_d      = 1'b0;
      grants_d = grants_q + GRANT_W'(1);
    end
    if (fire_any && (rule == RULE_IDLE)) begin
      x_d = 1'b1;
    end
  end

  // Counter tracks cycles spent waiting in T; a Crit grant or leaving T clears it.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      starve_d[i] = starve_q[i];
      if ((n_q[i] != ST_T) || (fire_vec[i] && (rule == RULE_CRIT))) begin
        starve_d[i] = '0;
      end else if (starve_q[i] < STARVE_W'(STARVE_LIMIT)) begin
        starve_d[i] = starve_q[i] + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        n_q[i]      <= ST_I;
        starve_q[i] <= '0;
      end
      x_q      <= 1'b1;
      fired_q  <= 1'b0;
      grants_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        n_q[i]      <= n_d[i];
        starve_q[i] <= starve_d[i];
      end
      x_q      <= x_d;
      fired_q  <= fire_any;
      grants_q <= grants_d;
    end
  end

  always_comb begin
    io_state  = '0;
    io_starve = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      io_state[2*i +: 2] = n_q[i];
      io_starve[i]       = (starve_q[i] == STARVE_W'(STARVE_LIMIT));
    end
  end

  assign io_x      = x_q;
  assign io_fired  = fired_q;
  assign io_grants = grants_q;

`ifdef MUTEX_INV_CHECK_EN
  localparam int CNT_W = $clog2(NUM_CLIENTS + 1);

  logic [CNT_W-1:0] ce_cnt;
  logic             violation;
  logic             inv_fail_q;

  always_comb begin
    ce_cnt = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if ((n_q[i] == ST_C) || (n_q[i] == ST_E)) begin
        ce_cnt = ce_cnt + CNT_W'(1);
      end
    end
    violation = (ce_cnt > CNT_W'(1)) ||
                (x_q && (ce_cnt != '0)) ||
                (!x_q && (ce_cnt == '0));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inv_fail_q <= 1'b0;
    end else if (violation) begin
      inv_fail_q <= 1'b1;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      assert (!violation);
    end
  end

  assign io_inv_fail = inv_fail_q;
`else
  assign io_inv_fail = 1'b0;
`endif

endmodule

// File: tb/tb_mutex_system_n.sv
// tb/tb_mutex_system_n.sv - randomized + directed check of mutex_system_n against a queue-free reference model
module tb_mutex_system_n;

  localparam int N     = 3;
  localparam int LIMIT = 4;
  localparam int GW    = 4;

  logic          clock;
  logic          reset;
  logic          en;
  logic [1:0]    rule;
  logic [1:0]    client;
  logic [2*N-1:0] io_state;
  logic          io_x;
  logic          io_fired;
  logic [N-1:0]  io_starve;
  logic [GW-1:0] io_grants;
  logic          io_inv_fail;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  mutex_system_n #(
    .NUM_CLIENTS (N),
    .CLIENT_W    (2),
    .STARVE_LIMIT(LIMIT),
    .GRANT_W     (GW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .io_en      (en),
    .io_rule    (rule),
    .io_client  (client),
    .io_state   (io_state),
    .io_x       (io_x),
    .io_fired   (io_fired),
    .io_starve  (io_starve),
    .io_grants  (io_grants),
    .io_inv_fail(io_inv_fail)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Reference model: client states as integers, starvation from entry time.
  int m_st [N];
  int m_enter [N];
  int m_x;
  int m_fired;
  int m_grants;
  int cyc = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) m_st[i] = 0;
      m_x      = 1;
      m_fired  = 0;
      m_grants = 0;
    end else begin
      int c;
      cyc++;
      m_fired = 0;
      c = int'(client);
      if (en && c < N) begin
        if (rule == 0 && m_st[c] == 0) begin
          m_st[c] = 1; m_enter[c] = cyc; m_fired = 1;
        end else if (rule == 1 && m_st[c] == 1 && m_x == 1) begin
          m_st[c] = 2; m_x = 0; m_grants = (m_grants + 1) % (1 << GW); m_fired = 1;
        end else if (rule == 2 && m_st[c] == 2) begin
          m_st[c] = 3; m_fired = 1;
        end else if (rule == 3 && m_st[c] == 3) begin
          m_st[c] = 0; m_x = 1; m_fired = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      logic [2*N-1:0] e_state;
      logic [N-1:0]   e_starve;
      for (int i = 0; i < N; i++) begin
        e_state[2*i +: 2] = 2'(m_st[i]);
        e_starve[i] = reset && (m_st[i] == 1) && ((cyc - m_enter[i]) >= LIMIT);
      end
      check("state",    32'(io_state),    32'(e_state));
      check("x",        32'(io_x),        32'(m_x));
      check("fired",    32'(io_fired),    32'(m_fired));
      check("starve",   32'(io_starve),   32'(e_starve));
      check("grants",   32'(io_grants),   32'(m_grants));
      check("inv_fail", 32'(io_inv_fail), 32'd0);
    end
  end

  // Drive a request, let one edge apply it, return 2 ns after that edge.
  task automatic step(input logic e, input logic [1:0] r, input logic [1:0] c);
    en = e; rule = r; client = c;
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 0; en = 0; rule = 0; client = 0;
    @(posedge clock); #2;
    chk_on = 1;
    @(posedge clock); #2;
    reset = 1;
    repeat (3) step(0, 0, 0);
    check("lit_reset_state", 32'(io_state), 32'h0);
    check("lit_reset_x", 32'(io_x), 32'h1);
    check("lit_reset_grants", 32'(io_grants), 32'h0);

    step(1, 0, 1); check("lit_try1", 32'(io_state), 32'b000100);
    step(1, 1, 1); check("lit_crit1", 32'(io_state), 32'b001000);
    check("lit_crit1_x", 32'(io_x), 32'h0);
    step(1, 2, 1); check("lit_exit1", 32'(io_state), 32'b001100);
    step(1, 3, 1); check("lit_idle1", 32'(io_state), 32'h0);
    check("lit_idle1_x", 32'(io_x), 32'h1);
    check("lit_idle1_fired", 32'(io_fired), 32'h1);
    check("lit_grants1", 32'(io_grants), 32'h1);

    step(1, 0, 0); step(1, 0, 2); step(1, 1, 0); step(1, 1, 2);
    check("lit_contend_fired", 32'(io_fired), 32'h0);
    check("lit_contend_state", 32'(io_state), 32'b010010);
    step(1, 2, 0); step(1, 3, 0);
    check("lit_starve_set", 32'(io_starve), 32'b100);
    step(0, 0, 0);
    check("lit_starve_hold", 32'(io_starve), 32'b100);
    step(1, 1, 2);
    check("lit_starve_clear", 32'(io_starve), 32'b000);
    check("lit_grants3", 32'(io_grants), 32'h3);
    step(1, 2, 2); step(1, 3, 2);

    step(1, 0, 3); check("lit_bad_client", 32'(io_fired), 32'h0);
    step(1, 2, 0); check("lit_exit_on_i", 32'(io_fired), 32'h0);

    step(1, 0, 0); step(1, 1, 0);
    reset = 0;
    #1;
    check("lit_async_state", 32'(io_state), 32'h0);
    check("lit_async_x", 32'(io_x), 32'h1);
    @(posedge clock); #2;
    reset = 1;

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 0;
        step(0, 0, 0);
        reset = 1;
      end else begin
        step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
    end

    @(negedge clock); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
